md_issue_ctrl: RTL and testbench

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

---
 rtl/md_pkg.sv | 36 +++
 rtl/md_issue_ctrl_if.sv | 32 +++
 rtl/md_funct_decode.sv | 34 +++
 rtl/md_issue_ctrl.sv | 94 +++++++++
 tb/tb_md_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue controller: funct codes,
// countdown lengths, FSM encoding and the registered strobe bundle.
package md_pkg;

  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned MULDLY  = 10;
  localparam int unsigned DIVDLY  = 30;

  localparam logic [FUNCT_W-1:0] F_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] F_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] F_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] F_MTLO  = 6'h13;
  localparam logic [FUNCT_W-1:0] F_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] F_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] F_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } md_state_e;

  typedef struct packed {
    logic mult_op;
    logic div_op;
    logic signed_op;
    logic store_hilo;
    logic load_hilo;
    logic hi_lo;
    logic ld_hi;
    logic ld_lo;
  } md_strobe_t;

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Pipeline <-> issue controller signal bundle; the pipeline is the master,
// the controller the slave.
interface md_issue_ctrl_if;

  logic                         InstrValid_s1;
  logic [md_pkg::FUNCT_W-1:0]   Funct_s1;
  logic                         Kill_s1;
  logic                         Stall_s1;
  logic                         MultOp;
  logic                         DivOp;
  logic                         SignedMDOp;
  logic                         StoreHiLo;
  logic                         LoadHiLo;
  logic                         HiLo;
  logic                         ldHi;
  logic                         ldLo;
  logic                         HLStall;
  logic                         MDBusy;

  modport master (
    output InstrValid_s1, Funct_s1, Kill_s1, Stall_s1,
    input  MultOp, DivOp, SignedMDOp, StoreHiLo, LoadHiLo, HiLo, ldHi, ldLo,
    input  HLStall, MDBusy
  );

  modport slave (
    input  InstrValid_s1, Funct_s1, Kill_s1, Stall_s1,
    output MultOp, DivOp, SignedMDOp, StoreHiLo, LoadHiLo, HiLo, ldHi, ldLo,
    output HLStall, MDBusy
  );

endinterface

// File: rtl/md_funct_decode.sv
// Combinational classification of the special-class funct field.
module md_funct_decode
  import md_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output logic               isMul,
  output logic               isDiv,
  output logic               isSigned,
  output logic               isMF,
  output logic               isMT,
  output logic               isHi
);

  always_comb begin
    isMul    = 1'b0;
    isDiv    = 1'b0;
    isSigned = 1'b0;
    isMF     = 1'b0;
    isMT     = 1'b0;
    isHi     = 1'b0;
    case (funct)
      F_MFHI:  begin isMF = 1'b1; isHi = 1'b1; end
      F_MTHI:  begin isMT = 1'b1; isHi = 1'b1; end
      F_MFLO:  isMF = 1'b1;
      F_MTLO:  isMT = 1'b1;
      F_MULT:  begin isMul = 1'b1; isSigned = 1'b1; end
      F_MULTU: isMul = 1'b1;
      F_DIV:   begin isDiv = 1'b1; isSigned = 1'b1; end
      F_DIVU:  isDiv = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Issues mult/div/HI-LO operations, tracks the mult/div latency with a
// countdown and interlocks HI/LO accesses until the result is ready.
module md_issue_ctrl
  import md_pkg::*;
(
  input  logic           Phi1,
  input  logic           Reset,
  md_issue_ctrl_if.slave bus
);

  logic             is_mul;
  logic             is_div;
  logic             is_signed;
  logic             is_mf;
  logic             is_mt;
  logic             is_hi;
  logic             known;
  logic             hl_stall;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  md_state_e        state;
  md_state_e        state_next;
  md_strobe_t       strb;
  md_strobe_t       strb_next;

  md_funct_decode u_decode (
    .funct    (bus.Funct_s1),
    .isMul    (is_mul),
    .isDiv    (is_div),
    .isSigned (is_signed),
    .isMF     (is_mf),
    .isMT     (is_mt),
    .isHi     (is_hi)
  );

  // An HI/LO access may go in the cycle the countdown drains from 1 to 0.
  assign known    = is_mul | is_div | is_mf | is_mt;
  assign hl_stall = bus.InstrValid_s1 & ~bus.Kill_s1 & (cnt > CNT_W'(1)) & (is_mf | is_mt);
  assign accept   = bus.InstrValid_s1 & ~bus.Kill_s1 & ~bus.Stall_s1 & ~hl_stall & known;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    strb_next  = '0;
    if (cnt != '0) begin
      cnt_next = cnt - CNT_W'(1);
    end
    if ((state != IDLE) && (cnt <= CNT_W'(1))) begin
      state_next = IDLE;
    end
    if (accept) begin
      if (is_mul) begin
        state_next = MUL_BUSY;
        cnt_next   = CNT_W'(MULDLY);
      end else if (is_div) begin
        state_next = DIV_BUSY;
        cnt_next   = CNT_W'(DIVDLY);
      end
      strb_next.mult_op    = is_mul;
      strb_next.div_op     = is_div;
      strb_next.signed_op  = (is_mul | is_div) & is_signed;
      strb_next.store_hilo = is_mt;
      strb_next.load_hilo  = is_mf;
      strb_next.hi_lo      = (is_mf | is_mt) & is_hi;
      strb_next.ld_hi      = is_mf & is_hi;
      strb_next.ld_lo      = is_mf & ~is_hi;
    end
  end

  always_ff @(posedge Phi1 or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      strb  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      strb  <= strb_next;
    end
  end

  assign bus.MultOp     = strb.mult_op;
  assign bus.DivOp      = strb.div_op;
  assign bus.SignedMDOp = strb.signed_op;
  assign bus.StoreHiLo  = strb.store_hilo;
  assign bus.LoadHiLo   = strb.load_hilo;
  assign bus.HiLo       = strb.hi_lo;
  assign bus.ldHi       = strb.ld_hi;
  assign bus.ldLo       = strb.ld_lo;
  assign bus.HLStall    = hl_stall;
  assign bus.MDBusy     = (state != IDLE);

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: cycle-table vectors, directed latency sequences and
// a randomized run against a countdown model.
module tb_md_issue_ctrl;

  localparam logic [5:0] C_MFHI  = 6'h10;
  localparam logic [5:0] C_MTHI  = 6'h11;
  localparam logic [5:0] C_MFLO  = 6'h12;
  localparam logic [5:0] C_MTLO  = 6'h13;
  localparam logic [5:0] C_MULT  = 6'h18;
  localparam logic [5:0] C_MULTU = 6'h19;
  localparam logic [5:0] C_DIV   = 6'h1A;
  localparam logic [5:0] C_DIVU  = 6'h1B;
  localparam logic [5:0] C_BAD   = 6'h20;

  // {MultOp, DivOp, SignedMDOp, StoreHiLo, LoadHiLo, HiLo, ldHi, ldLo}
  localparam logic [7:0] S_NONE  = 8'b0000_0000;
  localparam logic [7:0] S_MULT  = 8'b1010_0000;
  localparam logic [7:0] S_MULTU = 8'b1000_0000;
  localparam logic [7:0] S_DIV   = 8'b0110_0000;
  localparam logic [7:0] S_DIVU  = 8'b0100_0000;
  localparam logic [7:0] S_MTHI  = 8'b0001_0100;
  localparam logic [7:0] S_MTLO  = 8'b0001_0000;
  localparam logic [7:0] S_MFHI  = 8'b0000_1110;
  localparam logic [7:0] S_MFLO  = 8'b0000_1001;

  typedef struct {
    logic       v;
    logic [5:0] f;
    logic       k;
    logic       s;
    logic       hl;
    logic       busy;
    logic [7:0] str;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   rem;
  logic [7:0] m_str;
  vec_t tbl[$];

  md_issue_ctrl_if bus ();

  md_issue_ctrl dut (
    .Phi1  (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] get_str();
    return {bus.MultOp, bus.DivOp, bus.SignedMDOp, bus.StoreHiLo,
            bus.LoadHiLo, bus.HiLo, bus.ldHi, bus.ldLo};
  endfunction

  function automatic logic [7:0] strobe_of(logic [5:0] f);
    case (f)
      C_MULT:  return S_MULT;
      C_MULTU: return S_MULTU;
      C_DIV:   return S_DIV;
      C_DIVU:  return S_DIVU;
      C_MTHI:  return S_MTHI;
      C_MTLO:  return S_MTLO;
      C_MFHI:  return S_MFHI;
      C_MFLO:  return S_MFLO;
      default: return S_NONE;
    endcase
  endfunction

  function automatic int delay_of(logic [5:0] f);
    if (f == C_MULT || f == C_MULTU) return 10;
    if (f == C_DIV || f == C_DIVU) return 30;
    return 0;
  endfunction

  function automatic logic is_hilo(logic [5:0] f);
    return (f >= C_MFHI) && (f <= C_MTLO);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [5:0] f, input logic k, input logic s);
    bus.InstrValid_s1 = v;
    bus.Funct_s1      = f;
    bus.Kill_s1       = k;
    bus.Stall_s1      = s;
  endtask

  task automatic cyc(input logic v, input logic [5:0] f, input logic k, input logic s);
    set_in(v, f, k, s);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 6'h00, 1'b0, 1'b0);
    rst   = 1'b1;
    rem   = 0;
    m_str = S_NONE;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic add(input logic v, input logic [5:0] f, input logic k, input logic s,
                     input logic hl, input logic busy, input logic [7:0] str);
    vec_t r;
    r.v = v; r.f = f; r.k = k; r.s = s; r.hl = hl; r.busy = busy; r.str = str;
    tbl.push_back(r);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rem      = 0;
    m_str    = S_NONE;
    set_in(1'b0, 6'h00, 1'b0, 1'b0);

    // Reset state, with an HI access presented.
    repeat (2) @(posedge clk);
    #1;
    cyc(1'b1, C_MFHI, 1'b0, 1'b0);
    chk("rst_str", 32'(get_str()), 32'(S_NONE));
    chk("rst_hl", 32'(bus.HLStall), 32'd0);
    chk("rst_busy", 32'(bus.MDBusy), 32'd0);

    // Cycle table: MULT/MFLO latency, kill, stall, unknown funct.
    add(1, C_MULT, 0, 0, 0, 0, S_NONE);    // c0
    add(0, 6'h00,  0, 0, 0, 1, S_MULT);    // c1
    for (int c = 2; c <= 9; c++) add(1, C_MFLO, 0, 0, 1, 1, S_NONE);
    add(1, C_MFLO, 0, 0, 0, 1, S_NONE);    // c10 accepted
    add(0, 6'h00,  0, 0, 0, 0, S_MFLO);    // c11
    add(1, C_MULT, 1, 0, 0, 0, S_NONE);    // killed
    add(0, 6'h00,  0, 0, 0, 0, S_NONE);
    add(1, C_MFHI, 0, 1, 0, 0, S_NONE);    // stalled x3
    add(1, C_MFHI, 0, 1, 0, 0, S_NONE);
    add(1, C_MFHI, 0, 1, 0, 0, S_NONE);
    add(1, C_MFHI, 0, 0, 0, 0, S_NONE);
    add(0, 6'h00,  0, 0, 0, 0, S_MFHI);
    add(1, C_BAD,  0, 0, 0, 0, S_NONE);
    add(0, 6'h00,  0, 0, 0, 0, S_NONE);
    add(1, C_MULTU, 0, 0, 0, 0, S_NONE);
    add(1, C_BAD,  0, 0, 0, 1, S_MULTU);
    add(0, 6'h00,  0, 0, 0, 1, S_NONE);
    add(1, C_MTLO, 1, 0, 0, 1, S_NONE);    // kill masks the interlock
    add(1, C_MTLO, 0, 0, 1, 1, S_NONE);
    add(0, 6'h00,  0, 0, 0, 1, S_NONE);

    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].f, tbl[i].k, tbl[i].s);
      chk($sformatf("tbl%0d_hl", i), 32'(bus.HLStall), 32'(tbl[i].hl));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.MDBusy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_str", i), 32'(get_str()), 32'(tbl[i].str));
      step();
    end

    // DIVU then MTHI from cycle 5.
    do_reset();
    cyc(1, C_DIVU, 0, 0); step();
    cyc(0, 6'h00, 0, 0);
    chk("divu_str", 32'(get_str()), 32'(S_DIVU));
    step();
    repeat (3) begin cyc(0, 6'h00, 0, 0); step(); end
    for (int c = 5; c <= 29; c++) begin
      cyc(1, C_MTHI, 0, 0);
      chk($sformatf("mthi_stall_c%0d", c), 32'(bus.HLStall), 32'd1);
      step();
    end
    cyc(1, C_MTHI, 0, 0);
    chk("mthi_go_c30", 32'(bus.HLStall), 32'd0);
    step();
    cyc(0, 6'h00, 0, 0);
    chk("mthi_str_c31", 32'(get_str()), 32'(S_MTHI));
    chk("mthi_busy_c31", 32'(bus.MDBusy), 32'd0);
    step();

    // MULTU restarted by DIV at cycle 4.
    do_reset();
    cyc(1, C_MULTU, 0, 0); step();
    cyc(0, 6'h00, 0, 0);
    chk("multu_str", 32'(get_str()), 32'(S_MULTU));
    step();
    repeat (2) begin cyc(0, 6'h00, 0, 0); step(); end
    cyc(1, C_DIV, 0, 0); step();
    cyc(0, 6'h00, 0, 0);
    chk("restart_str_c5", 32'(get_str()), 32'(S_DIV));
    for (int c = 5; c <= 34; c++) begin
      cyc(0, 6'h00, 0, 0);
      chk($sformatf("restart_busy_c%0d", c), 32'(bus.MDBusy), 32'd1);
      step();
    end
    cyc(0, 6'h00, 0, 0);
    chk("restart_idle_c35", 32'(bus.MDBusy), 32'd0);

    // Reset pulse mid-DIV.
    do_reset();
    cyc(1, C_DIV, 0, 0); step();
    repeat (14) begin cyc(0, 6'h00, 0, 0); step(); end
    cyc(1, C_MFHI, 0, 0);
    chk("div_c15_busy", 32'(bus.MDBusy), 32'd1);
    chk("div_c15_hl", 32'(bus.HLStall), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.MDBusy), 32'd0);
    chk("midrst_hl", 32'(bus.HLStall), 32'd0);
    rst = 1'b0;
    #1;
    chk("postrst_hl", 32'(bus.HLStall), 32'd0);
    step();
    cyc(0, 6'h00, 0, 0);
    chk("postrst_str", 32'(get_str()), 32'(S_MFHI));
    chk("postrst_busy", 32'(bus.MDBusy), 32'd0);

    // Randomized run against the countdown model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic       v, k, s, exp_hl, acc;
      logic [5:0] f;
      int         pick;
      if ($urandom_range(99) == 0) begin
        rst = 1'b1;
        #1;
        rst   = 1'b0;
        rem   = 0;
        m_str = S_NONE;
      end
      v    = ($urandom_range(9) < 7);
      k    = ($urandom_range(9) == 0);
      s    = ($urandom_range(99) < 15);
      pick = $urandom_range(11);
      case (pick)
        0: f = C_MULT;  1: f = C_MULTU; 2: f = C_DIV;  3: f = C_DIVU;
        4: f = C_MFHI;  5: f = C_MTHI;  6: f = C_MFLO; 7: f = C_MTLO;
        8: f = C_MFLO;  9: f = C_MTHI;  10: f = C_BAD;
        default: f = 6'($urandom);
      endcase
      cyc(v, f, k, s);
      exp_hl = v & ~k & (rem > 1) & is_hilo(f);
      acc    = v & ~k & ~s & ~exp_hl & (strobe_of(f) != S_NONE);
      chk("rnd_hl", 32'(bus.HLStall), 32'(exp_hl));
      chk("rnd_busy", 32'(bus.MDBusy), 32'(rem != 0));
      chk("rnd_str", 32'(get_str()), 32'(m_str));
      step();
      m_str = acc ? strobe_of(f) : S_NONE;
      if (acc && delay_of(f) != 0) rem = delay_of(f);
      else if (rem > 0) rem = rem - 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
